// File: rtl/bpu_pkg.sv
//==============================================================================
// Module      : bpu_pkg
// Description : Shared counter encodings, reset state and index/tag width
//               helpers for the branch prediction unit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package bpu_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    localparam logic [1:0] c_INIT_STATE = WNT;

    function automatic int idx_width(input int entries);
        return $clog2(entries);
    endfunction

    // Word-aligned PCs: index starts at bit 2, tag takes everything above it.
    function automatic int tag_width(input int entries);
        return 32 - $clog2(entries) - 2;
    endfunction

    function automatic logic [1:0] bht_next(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) nxt = cur + 2'd1;
        end else begin
            if (cur != SNT) nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bpu_btb.sv
//==============================================================================
// Module      : bpu_btb
// Description : Direct-mapped branch target buffer with combinational lookup
//               and a single registered write port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bpu_btb
    import bpu_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] lookup_pc,
    input  logic        lookup_valid,
    output logic        hit,
    output logic [31:0] target,
    input  logic        wr_en,
    input  logic [31:0] wr_pc,
    input  logic [31:0] wr_target
);

    localparam int c_IDX_W = idx_width(ENTRIES);
    localparam int c_TAG_W = tag_width(ENTRIES);

    logic               r_valid  [ENTRIES];
    logic [c_TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];

    logic [c_IDX_W-1:0] w_rd_idx;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_TAG_W-1:0] w_rd_tag;
    logic [c_TAG_W-1:0] w_wr_tag;
    logic [3:0]         w_unused_lsbs;

    assign w_rd_idx      = lookup_pc[c_IDX_W+1:2];
    assign w_rd_tag      = lookup_pc[31:c_IDX_W+2];
    assign w_wr_idx      = wr_pc[c_IDX_W+1:2];
    assign w_wr_tag      = wr_pc[31:c_IDX_W+2];
    assign w_unused_lsbs = {lookup_pc[1:0], wr_pc[1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
        end else if (wr_en) begin
            r_valid[w_wr_idx]  <= 1'b1;
            r_tag[w_wr_idx]    <= w_wr_tag;
            r_target[w_wr_idx] <= wr_target;
        end
    end

    // Reads see only registered state, so a same-cycle write is not bypassed.
    assign hit    = lookup_valid & r_valid[w_rd_idx] & (r_tag[w_rd_idx] == w_rd_tag);
    assign target = hit ? r_target[w_rd_idx] : 32'd0;

endmodule

`default_nettype wire

// File: rtl/branch_predictor_unit.sv
//==============================================================================
// Module      : branch_predictor_unit
// Description : 2-bit BHT plus direct-mapped BTB predictor with saturating
//               branch/mispredict statistics counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module branch_predictor_unit
    import bpu_pkg::*;
#(
    parameter int         BHT_ENTRIES = 64,
    parameter int         BTB_ENTRIES = 16,
    parameter logic [1:0] INIT_STATE  = c_INIT_STATE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] IF_PC,
    input  logic        IF_valid,
    output logic        branch_prediction,
    output logic [31:0] predicted_target,
    output logic        btb_hit,
    input  logic        EX_branch_inst,
    input  logic        EX_branch_taken,
    input  logic        EX_branch_mispredict,
    input  logic [31:0] EX_MEM_PC,
    input  logic [31:0] EX_branch_target,
    output logic [31:0] bpu_branch_count,
    output logic [31:0] bpu_mispredict_count
);

    localparam int          c_BHT_IDX_W = idx_width(BHT_ENTRIES);
    localparam logic [31:0] c_CNT_MAX   = 32'hFFFF_FFFF;

    logic [1:0]             r_bht [BHT_ENTRIES];
    logic [31:0]            r_branch_count;
    logic [31:0]            r_mispredict_count;

    logic [c_BHT_IDX_W-1:0] w_rd_idx;
    logic [c_BHT_IDX_W-1:0] w_wr_idx;
    logic                   w_btb_hit;
    logic [31:0]            w_btb_target;

    assign w_rd_idx = IF_PC[c_BHT_IDX_W+1:2];
    assign w_wr_idx = EX_MEM_PC[c_BHT_IDX_W+1:2];

    bpu_btb #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk          (clk),
        .reset_n      (reset_n),
        .lookup_pc    (IF_PC),
        .lookup_valid (IF_valid),
        .hit          (w_btb_hit),
        .target       (w_btb_target),
        .wr_en        (EX_branch_inst & EX_branch_taken),
        .wr_pc        (EX_MEM_PC),
        .wr_target    (EX_branch_target)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= INIT_STATE;
            end
        end else if (EX_branch_inst) begin
            r_bht[w_wr_idx] <= bht_next(r_bht[w_wr_idx], EX_branch_taken);
        end
    end

    // Statistics stick at all-ones rather than wrapping back to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (EX_branch_inst) begin
            if (r_branch_count != c_CNT_MAX) begin
                r_branch_count <= r_branch_count + 32'd1;
            end
            if (EX_branch_mispredict && (r_mispredict_count != c_CNT_MAX)) begin
                r_mispredict_count <= r_mispredict_count + 32'd1;
            end
        end
    end

    assign btb_hit              = w_btb_hit;
    assign predicted_target     = w_btb_target;
    assign branch_prediction    = w_btb_hit & r_bht[w_rd_idx][1];
    assign bpu_branch_count     = r_branch_count;
    assign bpu_mispredict_count = r_mispredict_count;

endmodule

`default_nettype wire
